cpu_ctrl: RTL and testbench

Fetch/decode/execute control unit with accumulator for the 8-bit CPU, sitting directly upstream of the 16-entry register file. Reads 16-bit instructions from a synchronous program ROM. Sequences register-file reads and writes through the file_en/operation/addr/ac port group. Performs accumulator arithmetic on returned file_out data and handles PC updates, branches and halt.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_ctrl_alu8.sv | 34 +++
 rtl/cpu_ctrl.sv | 123 ++++++++++++
 tb/tb_cpu_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control unit and its register file.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDR = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] FILE_RD = 4'b0000;
  localparam logic [3:0] FILE_WR = 4'b0001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Ops that touch the register file in EXEC.
  function automatic logic uses_file(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR) || ((op >= OP_ADD) && (op <= OP_XOR));
  endfunction

  // Ops whose register-file read result is folded into AC in WB.
  function automatic logic needs_wb(input logic [3:0] op);
    return (op == OP_LDR) || ((op >= OP_ADD) && (op <= OP_XOR));
  endfunction

endpackage

// File: rtl/cpu_ctrl_alu8.sv
// Accumulator ALU: combines AC with register-file data during WB.
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] opcode,
  output logic [7:0] result,
  output logic       c_out
);

  logic [8:0] w_sum;
  assign w_sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = b;
    c_out  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = w_sum[7:0];
        c_out  = w_sum[8];
      end
      OP_SUB: begin
        result = a - b;
        c_out  = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer with accumulator, flags and PC for the 8-bit CPU.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc_out,
  input  logic [15:0] instr_in,
  output logic        file_en,
  output logic [3:0]  operation,
  output logic [7:0]  addr,
  output logic [7:0]  ac,
  input  logic [7:0]  file_out,
  output logic        zero,
  output logic        carry,
  output logic        halted
);

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [7:0]  r_ac;
  logic        r_zero;
  logic        r_carry;
  logic        r_file_en;
  logic [3:0]  r_op;
  logic [7:0]  r_addr;
  logic        r_halted;

  logic [3:0]  w_op;
  logic [3:0]  w_dec_op;
  logic [7:0]  w_imm;
  logic [7:0]  w_alu_res;
  logic        w_alu_c;
  logic        w_unused;

  assign w_op     = r_ir[15:12];
  assign w_imm    = r_ir[7:0];
  assign w_dec_op = instr_in[15:12];
  assign w_unused = ^r_ir[11:8];

  alu8 u_alu (
    .a      (r_ac),
    .b      (file_out),
    .opcode (w_op),
    .result (w_alu_res),
    .c_out  (w_alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_ac      <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_file_en <= 1'b0;
      r_op      <= FILE_RD;
      r_addr    <= '0;
      r_halted  <= 1'b0;
    end else begin
      // Port group is only non-zero for the single EXEC cycle set up in DECODE.
      r_file_en <= 1'b0;
      r_op      <= FILE_RD;
      r_addr    <= '0;
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= instr_in;
          r_pc    <= r_pc + 8'd1;
          r_state <= S_EXEC;
          if (uses_file(w_dec_op)) begin
            r_file_en <= 1'b1;
            r_op      <= (w_dec_op == OP_STR) ? FILE_WR : FILE_RD;
            r_addr    <= {4'b0000, instr_in[3:0]};
          end
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          if (needs_wb(w_op)) begin
            r_state <= S_WB;
          end else begin
            case (w_op)
              OP_LDI: begin
                r_ac   <= w_imm;
                r_zero <= (w_imm == 8'h00);
              end
              OP_JMP: r_pc <= w_imm;
              OP_JZ:  if (r_zero)  r_pc <= w_imm;
              OP_JC:  if (r_carry) r_pc <= w_imm;
              OP_HLT: begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_WB: begin
          r_ac    <= w_alu_res;
          r_zero  <= (w_alu_res == 8'h00);
          if (w_op != OP_LDR) r_carry <= w_alu_c;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign pc_out    = r_pc;
  assign ac        = r_ac;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign file_en   = r_file_en;
  assign operation = r_op;
  assign addr      = r_addr;
  assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: ROM + register file environment and an instruction-level model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_out, addr, ac;
  logic [7:0]  file_out = 8'h00;
  logic [15:0] instr_in = 16'h0000;
  logic        file_en, zero, carry, halted;
  logic [3:0]  operation;

  logic [15:0] rom [256];
  logic [7:0]  rf [16];
  logic [7:0]  rf_init [16];
  logic        rf_load = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // Instruction-level model state.
  logic [7:0] m_pc, m_ac;
  logic       m_z, m_c;
  logic [7:0] m_rf [16];

  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .instr_in(instr_in),
    .file_en(file_en), .operation(operation), .addr(addr), .ac(ac),
    .file_out(file_out), .zero(zero), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM and register file.
  always @(posedge clk) begin
    instr_in <= rom[pc_out];
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
    end else if (file_en) begin
      if (operation == 4'b0001) rf[addr[3:0]] <= ac;
      else                      file_out <= rf[addr[3:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_load = 1'b1;
    step();
    step();
    chk8("rst_pc", pc_out, 8'h00);
    chk8("rst_ac", ac, 8'h00);
    chk1("rst_fe", file_en, 1'b0);
    chk8("rst_opaddr", {operation, addr[3:0]}, 8'h00);
    chk1("rst_z", zero, 1'b0);
    chk1("rst_c", carry, 1'b0);
    chk1("rst_halt", halted, 1'b0);
    rst = 1'b0;
    rf_load = 1'b0;
    m_pc = 8'h00; m_ac = 8'h00; m_z = 1'b0; m_c = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = rf_init[i];
  endtask

  // Runs from a FETCH sample point, one instruction at a time, until HLT or budget.
  task automatic run_prog(input int max_instr);
    logic [15:0] ir;
    logic [3:0]  opc, r;
    logic [7:0]  opd, b;
    logic        exp_fe, wb;
    int          s;
    for (int n = 0; n < max_instr; n++) begin
      ir  = rom[m_pc];
      opc = ir[15:12];
      opd = ir[7:0];
      r   = opd[3:0];
      b   = m_rf[r];
      chk8("fetch_pc", pc_out, m_pc);
      chk8("fetch_ac", ac, m_ac);
      chk1("fetch_z", zero, m_z);
      chk1("fetch_c", carry, m_c);
      chk1("fetch_halt", halted, 1'b0);
      step();
      chk1("decode_fe", file_en, 1'b0);
      step();
      exp_fe = (opc == 4'h1) || (opc == 4'h2) || (opc >= 4'h4 && opc <= 4'h8);
      wb     = exp_fe && (opc != 4'h2);
      chk1("exec_fe", file_en, exp_fe);
      if (exp_fe) begin
        chk8("exec_op", {4'h0, operation}, (opc == 4'h2) ? 8'h01 : 8'h00);
        chk8("exec_addr", addr, {4'h0, r});
        if (opc == 4'h2) chk8("exec_ac", ac, m_ac);
      end
      m_pc = m_pc + 8'd1;
      case (opc)
        4'h1: m_ac = b;
        4'h2: m_rf[r] = m_ac;
        4'h3: m_ac = opd;
        4'h4: begin
          s = int'(m_ac) + int'(b);
          m_c = (s > 255);
          m_ac = 8'(s % 256);
        end
        4'h5: begin
          m_c = (m_ac < b);
          m_ac = 8'((int'(m_ac) - int'(b) + 256) % 256);
        end
        4'h6: begin m_ac = m_ac & b; m_c = 1'b0; end
        4'h7: begin m_ac = m_ac | b; m_c = 1'b0; end
        4'h8: begin m_ac = m_ac ^ b; m_c = 1'b0; end
        4'h9: m_pc = opd;
        4'hA: if (m_z) m_pc = opd;
        4'hB: if (m_c) m_pc = opd;
        default: ;
      endcase
      if (wb || opc == 4'h3) m_z = (m_ac == 8'h00);
      if (wb) begin
        step();
        chk1("wb_fe", file_en, 1'b0);
      end
      step();
      if (opc == 4'hF) begin
        for (int k = 0; k < 10; k++) begin
          chk1("halt_flag", halted, 1'b1);
          chk8("halt_pc", pc_out, m_pc);
          chk1("halt_fe", file_en, 1'b0);
          chk8("halt_ac", ac, m_ac);
          chk1("halt_z", zero, m_z);
          chk1("halt_c", carry, m_c);
          step();
        end
        break;
      end
    end
    for (int i = 0; i < 16; i++) chk8("regfile", rf[i], m_rf[i]);
  endtask

  initial begin
    // Directed program covering the arithmetic, branch, wrap and halt cases.
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
    rf_init[2] = 8'h20; rf_init[3] = 8'h03; rf_init[7] = 8'h07;
    rom[8'h00] = 16'hB060;  // JC 60: untaken from reset, taken after the wrap
    rom[8'h01] = 16'h3005;
    rom[8'h02] = 16'h2003;
    rom[8'h03] = 16'h1003;
    rom[8'h04] = 16'h30F0;
    rom[8'h05] = 16'h4002;
    rom[8'h06] = 16'h5002;
    rom[8'h07] = 16'h3007;
    rom[8'h08] = 16'h5007;
    rom[8'h09] = 16'hA040;
    rom[8'h40] = 16'hB080;
    rom[8'h41] = 16'h30F0;
    rom[8'h42] = 16'h4002;
    rom[8'h43] = 16'h90FF;
    rom[8'hFF] = 16'h0000;
    rom[8'h60] = 16'hF000;
    do_reset();
    run_prog(40);
    chk8("dir_final_ac", ac, 8'h10);
    chk1("dir_final_c", carry, 1'b1);
    chk8("dir_final_pc", pc_out, 8'h61);
    chk8("dir_r3", rf[3], 8'h05);

    // Reset landing in the DECODE cycle of STR r5.
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h3033;
    rom[1] = 16'h2005;
    rf_init[5] = 8'hA5;
    do_reset();
    step(); step(); step();     // LDI: FETCH, DECODE, EXEC
    chk8("pre_str_pc", pc_out, 8'h01);
    step();                     // DECODE of STR
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk8("abort_pc", pc_out, 8'h00);
    chk1("abort_fe0", file_en, 1'b0);
    chk8("abort_ac", ac, 8'h00);
    step();
    chk1("abort_fe1", file_en, 1'b0);
    chk8("abort_r5", rf[5], 8'hA5);

    // Random programs.
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 256; i++) begin
        logic [3:0] o;
        o = ($urandom_range(0, 99) < 2) ? 4'hF : 4'($urandom_range(0, 14));
        rom[i] = {o, 4'($urandom), 8'($urandom)};
      end
      for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
      do_reset();
      run_prog(150);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
